// File: rtl/rd_return_queue.sv
// Read-side front end: issues line reads with IDs, buffers returned lines and hands them back in issue order.
// Latency: accept -> rstart_rq one cycle later; rdat_m_valid -> rsp_valid one cycle later (no bypass).
// Backpressure: credit based; req_ready drops when outstanding IDs plus buffered responses reach DEPTH.
module rd_return_queue #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int DW    = 128,
    parameter int AW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [AW-1:0]   req_addr,
    output logic            req_ready,
    output logic            rstart_rq,
    output logic [AW-1:0]   rin_addr,
    output logic [ID_W-1:0] next_rid,
    output logic            rqfull_1,
    input  logic [DW-1:0]   rdat_m_data,
    input  logic            rdat_m_valid,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_data,
    output logic [ID_W-1:0] rsp_id,
    input  logic            rsp_ready,
    output logic            err_unexp
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] NEAR_C = CW'(DEPTH - 1);

    logic [CW-1:0]   used_q;
    logic [CW-1:0]   used_d;
    logic [ID_W-1:0] id_cnt;

    logic [ID_W-1:0] idq_mem [DEPTH];
    logic [PW-1:0]   idq_wp;
    logic [PW-1:0]   idq_rp;
    logic [CW-1:0]   idq_cnt;

    logic [DW-1:0]   rsp_mem_dat [DEPTH];
    logic [ID_W-1:0] rsp_mem_id  [DEPTH];
    logic [PW-1:0]   rsp_wp;
    logic [PW-1:0]   rsp_rp;
    logic [CW-1:0]   rsp_cnt;

    logic accept;
    logic pop;
    logic ret_ok;
    logic ret_bad;

    assign req_ready = (used_q < FULL_C);
    assign accept    = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;
    assign ret_ok    = rdat_m_valid & (idq_cnt != '0);
    assign ret_bad   = rdat_m_valid & (idq_cnt == '0);

    assign rsp_valid = (rsp_cnt != '0);
    assign rsp_data  = rsp_mem_dat[rsp_rp];
    assign rsp_id    = rsp_mem_id[rsp_rp];

    // Next credit count: accept takes a credit, a response pop returns one; a data return only moves it.
    always_comb begin
        used_d = used_q;
        if (accept && !pop) begin
            used_d = used_q + CW'(1);
        end else if (!accept && pop) begin
            used_d = used_q - CW'(1);
        end
    end

    // Credit counter and its registered near-full flag for read_channels_mngr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used_q   <= '0;
            rqfull_1 <= 1'b0;
        end else begin
            used_q   <= used_d;
            rqfull_1 <= (used_d >= NEAR_C);
        end
    end

    // Issue path: one-cycle start pulse, address/ID held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstart_rq <= 1'b0;
            rin_addr  <= '0;
            next_rid  <= '0;
            id_cnt    <= '0;
        end else begin
            rstart_rq <= accept;
            if (accept) begin
                rin_addr <= req_addr;
                next_rid <= id_cnt;
                id_cnt   <= id_cnt + ID_W'(1);
            end
        end
    end

    // ID queue: IDs of issued but not yet returned reads, oldest at the read pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idq_wp  <= '0;
            idq_rp  <= '0;
            idq_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idq_mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                idq_mem[idq_wp] <= id_cnt;
                idq_wp          <= idq_wp + PW'(1);
            end
            if (ret_ok) begin
                idq_rp <= idq_rp + PW'(1);
            end
            if (accept && !ret_ok) begin
                idq_cnt <= idq_cnt + CW'(1);
            end else if (!accept && ret_ok) begin
                idq_cnt <= idq_cnt - CW'(1);
            end
        end
    end

    // Show-ahead response FIFO: returned line tagged with the ID at the head of the ID queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_wp  <= '0;
            rsp_rp  <= '0;
            rsp_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rsp_mem_dat[i] <= '0;
                rsp_mem_id[i]  <= '0;
            end
        end else begin
            if (ret_ok) begin
                rsp_mem_dat[rsp_wp] <= rdat_m_data;
                rsp_mem_id[rsp_wp]  <= idq_mem[idq_rp];
                rsp_wp              <= rsp_wp + PW'(1);
            end
            if (pop) begin
                rsp_rp <= rsp_rp + PW'(1);
            end
            if (ret_ok && !pop) begin
                rsp_cnt <= rsp_cnt + CW'(1);
            end else if (!ret_ok && pop) begin
                rsp_cnt <= rsp_cnt - CW'(1);
            end
        end
    end

    // Sticky flag for a returned line with nothing outstanding; the line itself is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unexp <= 1'b0;
        end else if (ret_bad) begin
            err_unexp <= 1'b1;
        end
    end

    a_idq_no_ovf: assert property (@(posedge clk) disable iff (rst)
        !(accept && (idq_cnt == FULL_C)));
    a_idq_no_udf: assert property (@(posedge clk) disable iff (rst)
        !(ret_ok && (idq_cnt == '0)));
    a_rsp_no_ovf: assert property (@(posedge clk) disable iff (rst)
        !(ret_ok && !pop && (rsp_cnt == FULL_C)));
    a_rsp_no_udf: assert property (@(posedge clk) disable iff (rst)
        !(pop && (rsp_cnt == '0)));
    a_credit_sum: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, used_q} == ({1'b0, idq_cnt} + {1'b0, rsp_cnt})));

endmodule

// File: tb/tb_rd_return_queue.sv
module tb_rd_return_queue;

    localparam int DEPTH = 4;
    localparam int ID_W  = 4;
    localparam int DW    = 128;
    localparam int AW    = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic            req_ready;
    logic            rstart_rq;
    logic [AW-1:0]   rin_addr;
    logic [ID_W-1:0] next_rid;
    logic            rqfull_1;
    logic [DW-1:0]   rdat_m_data = '0;
    logic            rdat_m_valid = 1'b0;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [ID_W-1:0] rsp_id;
    logic            rsp_ready = 1'b0;
    logic            err_unexp;

    int total = 0;
    int bad   = 0;

    rd_return_queue #(.DEPTH(DEPTH), .ID_W(ID_W), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rstart_rq(rstart_rq), .rin_addr(rin_addr), .next_rid(next_rid),
        .rqfull_1(rqfull_1),
        .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding IDs and buffered responses as plain queues.
    logic [ID_W-1:0] mq_id[$];
    logic [DW-1:0]   mr_dat[$];
    logic [ID_W-1:0] mr_id[$];
    int              m_idc;
    bit              m_err;
    bit              m_start;
    logic [AW-1:0]   m_addr;
    logic [ID_W-1:0] m_rid;
    bit              m_full;

    function automatic int m_used();
        return mq_id.size() + mr_dat.size();
    endfunction

    task automatic model_reset();
        mq_id.delete(); mr_dat.delete(); mr_id.delete();
        m_idc = 0; m_err = 0; m_start = 0; m_addr = '0; m_rid = '0; m_full = 0;
    endtask

    function automatic logic [DW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock: model consumes the inputs present before the edge; ends 1 unit after the edge.
    task automatic cyc();
        bit acc, pp, rv;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        acc = req_valid && (m_used() < DEPTH);
        pp  = rsp_ready && (mr_dat.size() > 0);
        rv  = rdat_m_valid;
        d   = rdat_m_data;
        a   = req_addr;
        @(posedge clk);
        if (pp) begin
            void'(mr_dat.pop_front());
            void'(mr_id.pop_front());
        end
        if (rv) begin
            if (mq_id.size() > 0) begin
                mr_id.push_back(mq_id.pop_front());
                mr_dat.push_back(d);
            end else begin
                m_err = 1;
            end
        end
        if (acc) begin
            mq_id.push_back(ID_W'(m_idc));
            m_start = 1; m_addr = a; m_rid = ID_W'(m_idc);
            m_idc = (m_idc + 1) % (1 << ID_W);
        end else begin
            m_start = 0;
        end
        m_full = (m_used() >= DEPTH - 1);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_addr = '0; rdat_m_valid = 0; rdat_m_data = '0; rsp_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #12;
        total++;
        if ({rstart_rq, rsp_valid, err_unexp, rqfull_1, req_ready} !== 5'b00001) begin
            bad++; $display("FAIL reset_flags: got %b want 00001", {rstart_rq, rsp_valid, err_unexp, rqfull_1, req_ready});
        end
        total++;
        if ({rin_addr, next_rid, rsp_id} !== '0 || rsp_data !== '0) begin
            bad++; $display("FAIL reset_buses: got addr=%h rid=%h id=%h data=%h want 0", rin_addr, next_rid, rsp_id, rsp_data);
        end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_single();
        logic [DW-1:0] line;
        line = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
        req_valid = 1; req_addr = 32'hDEADDEAD;
        cyc();
        req_valid = 0; req_addr = '0;
        total++;
        if ({rstart_rq, rin_addr, next_rid} !== {1'b1, 32'hDEADDEAD, 4'h0}) begin
            bad++; $display("FAIL single_issue: got start=%b addr=%h rid=%h want 1 deaddead 0", rstart_rq, rin_addr, next_rid);
        end
        for (int i = 0; i < 8; i++) cyc();
        total++;
        if (rstart_rq !== 1'b0 || rin_addr !== 32'hDEADDEAD || next_rid !== 4'h0) begin
            bad++; $display("FAIL single_hold: got start=%b addr=%h rid=%h want 0 deaddead 0", rstart_rq, rin_addr, next_rid);
        end
        rdat_m_valid = 1; rdat_m_data = line;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_no_bypass: got rsp_valid=%b want 0", rsp_valid);
        end
        cyc();
        rdat_m_valid = 0; rdat_m_data = '0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== line || rsp_id !== 4'h0) begin
            bad++; $display("FAIL single_rsp: got v=%b data=%h id=%h want 1 %h 0", rsp_valid, rsp_data, rsp_id, line);
        end
        cyc();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== line || rsp_id !== 4'h0) begin
            bad++; $display("FAIL single_stable: got v=%b data=%h id=%h want 1 %h 0", rsp_valid, rsp_data, rsp_id, line);
        end
        rsp_ready = 1;
        cyc();
        rsp_ready = 0;
        total++;
        if ({rsp_valid, req_ready, rqfull_1} !== 3'b010) begin
            bad++; $display("FAIL single_pop: got v/rdy/full=%b want 010", {rsp_valid, req_ready, rqfull_1});
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_addr = $urandom;
            total++;
            if (req_ready !== 1'b1) begin
                bad++; $display("FAIL fill_ready_%0d: got %b want 1", i, req_ready);
            end
            cyc();
            total++;
            if (rstart_rq !== 1'b1 || next_rid !== ID_W'(i) || rqfull_1 !== (i >= 2)) begin
                bad++; $display("FAIL fill_issue_%0d: got start=%b rid=%h full=%b want 1 %h %b", i, rstart_rq, next_rid, rqfull_1, i, (i >= 2));
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (req_ready !== 1'b0 || rstart_rq !== 1'b0) begin
                bad++; $display("FAIL fill_blocked_%0d: got rdy=%b start=%b want 0 0", i, req_ready, rstart_rq);
            end
        end
        req_valid = 0;
        // Return all four lines into the buffer while nothing is popped.
        for (int i = 0; i < 4; i++) begin
            rdat_m_valid = 1; rdat_m_data = rnd_line();
            cyc();
        end
        rdat_m_valid = 0;
        // Full: the request is refused this cycle even though a pop happens.
        req_valid = 1; req_addr = 32'h1234_5678; rsp_ready = 1;
        total++;
        if (req_ready !== 1'b0 || rsp_id !== 4'h0) begin
            bad++; $display("FAIL simul_full: got rdy=%b id=%h want 0 0", req_ready, rsp_id);
        end
        cyc();
        total++;
        if (rstart_rq !== 1'b0 || req_ready !== 1'b1 || rsp_id !== 4'h1) begin
            bad++; $display("FAIL simul_pop: got start=%b rdy=%b id=%h want 0 1 1", rstart_rq, req_ready, rsp_id);
        end
        // Accept and pop together: credits unchanged.
        cyc();
        req_valid = 0; rsp_ready = 0;
        total++;
        if (rstart_rq !== 1'b1 || next_rid !== 4'h4 || rin_addr !== 32'h1234_5678 || req_ready !== 1'b1 || rqfull_1 !== 1'b1) begin
            bad++; $display("FAIL simul_accept: got start=%b rid=%h addr=%h rdy=%b full=%b want 1 4 12345678 1 1", rstart_rq, next_rid, rin_addr, req_ready, rqfull_1);
        end
        // Drain against the model.
        rsp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            rdat_m_valid = (mq_id.size() > 0); rdat_m_data = rnd_line();
            if (rsp_valid) begin
                total++;
                if (mr_dat.size() == 0 || rsp_data !== mr_dat[0] || rsp_id !== mr_id[0]) begin
                    bad++; $display("FAIL drain_%0d: got data=%h id=%h", i, rsp_data, rsp_id);
                end
            end
            cyc();
        end
        idle_inputs();
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL drain_end: got v=%b rdy=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_order();
        logic [DW-1:0] a, b;
        a = rnd_line(); b = rnd_line();
        do_reset();
        req_valid = 1; req_addr = 32'h100; cyc();
        req_addr = 32'h140; cyc();
        req_valid = 0;
        rsp_ready = 1;
        rdat_m_valid = 1; rdat_m_data = a; cyc();
        rdat_m_data = b;
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== a || rsp_id !== 4'h0) begin
            bad++; $display("FAIL order_a: got v=%b data=%h id=%h want 1 %h 0", rsp_valid, rsp_data, rsp_id, a);
        end
        cyc();
        rdat_m_valid = 0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== b || rsp_id !== 4'h1) begin
            bad++; $display("FAIL order_b: got v=%b data=%h id=%h want 1 %h 1", rsp_valid, rsp_data, rsp_id, b);
        end
        cyc();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL order_empty: got v=%b want 0", rsp_valid);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            req_valid = 1; req_addr = $urandom;
            cyc();
            req_valid = 0;
            total++;
            if (rstart_rq !== 1'b1 || next_rid !== ID_W'(i % 16)) begin
                bad++; $display("FAIL wrap_rid_%0d: got start=%b rid=%h want 1 %h", i, rstart_rq, next_rid, i % 16);
            end
            d = rnd_line();
            rdat_m_valid = 1; rdat_m_data = d;
            cyc();
            rdat_m_valid = 0;
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(i % 16) || rsp_data !== d) begin
                bad++; $display("FAIL wrap_rsp_%0d: got v=%b id=%h data=%h want 1 %h %h", i, rsp_valid, rsp_id, rsp_data, i % 16, d);
            end
            rsp_ready = 1;
            cyc();
            rsp_ready = 0;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid    = ($urandom_range(0, 99) < 55);
            req_addr     = $urandom;
            rdat_m_valid = (mq_id.size() > 0) && ($urandom_range(0, 99) < 50);
            rdat_m_data  = rnd_line();
            rsp_ready    = ($urandom_range(0, 99) < 45);
            total++;
            if (req_ready !== (m_used() < DEPTH) || rsp_valid !== (mr_dat.size() > 0)) begin
                bad++; $display("FAIL rand_flow_%0d: got rdy=%b v=%b want %b %b", i, req_ready, rsp_valid, (m_used() < DEPTH), (mr_dat.size() > 0));
            end
            if (mr_dat.size() > 0) begin
                total++;
                if (rsp_data !== mr_dat[0] || rsp_id !== mr_id[0]) begin
                    bad++; $display("FAIL rand_head_%0d: got %h/%h want %h/%h", i, rsp_data, rsp_id, mr_dat[0], mr_id[0]);
                end
            end
            cyc();
            total++;
            if (rstart_rq !== m_start || rqfull_1 !== m_full || err_unexp !== m_err ||
                (m_start && (rin_addr !== m_addr || next_rid !== m_rid))) begin
                bad++; $display("FAIL rand_issue_%0d: got start=%b full=%b err=%b addr=%h rid=%h want %b %b %b %h %h",
                                i, rstart_rq, rqfull_1, err_unexp, rin_addr, next_rid, m_start, m_full, m_err, m_addr, m_rid);
            end
        end
        idle_inputs();
    endtask

    task automatic test_unexp_reset();
        do_reset();
        rdat_m_valid = 1; rdat_m_data = rnd_line();
        cyc();
        rdat_m_valid = 0;
        total++;
        if (err_unexp !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL unexp: got err=%b v=%b rdy=%b want 1 0 1", err_unexp, rsp_valid, req_ready);
        end
        cyc(); cyc();
        total++;
        if (err_unexp !== 1'b1) begin
            bad++; $display("FAIL unexp_sticky: got %b want 1", err_unexp);
        end
        // Burst in flight, then reset between clock edges.
        req_valid = 1; req_addr = $urandom; cyc();
        req_addr = $urandom; cyc();
        rdat_m_valid = 1; rdat_m_data = rnd_line(); cyc();
        rdat_m_valid = 0;
        #2;
        rst = 1;
        #1;
        total++;
        if ({rstart_rq, rsp_valid, err_unexp, rqfull_1, req_ready} !== 5'b00001 ||
            rin_addr !== '0 || next_rid !== '0 || rsp_id !== '0 || rsp_data !== '0) begin
            bad++; $display("FAIL async_reset: got flags=%b addr=%h rid=%h want 00001 0 0",
                            {rstart_rq, rsp_valid, err_unexp, rqfull_1, req_ready}, rin_addr, next_rid);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        total++;
        if (req_ready !== 1'b1 || err_unexp !== 1'b0) begin
            bad++; $display("FAIL reset_release: got rdy=%b err=%b want 1 0", req_ready, err_unexp);
        end
        rdat_m_valid = 1; rdat_m_data = rnd_line();
        cyc();
        rdat_m_valid = 0;
        total++;
        if (err_unexp !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset_data: got err=%b v=%b want 1 0", err_unexp, rsp_valid);
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fill();
        test_order();
        test_wrap();
        test_random();
        test_unexp_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
